// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the MIPI CSI-2 receive path.
//   - Data-type codes for frame markers and the RAW long packets forwarded to the depacker.
//   - Short/long packet boundary on the data-type field.
//   - Packet decoder FSM state encoding.
package mipi_csi_pkg;

    localparam logic [5:0] DtFrameStart = 6'h00;
    localparam logic [5:0] DtFrameEnd   = 6'h01;
    localparam logic [5:0] DtRaw10      = 6'h2B;
    localparam logic [5:0] DtRaw12      = 6'h2C;
    localparam logic [5:0] DtRaw14      = 6'h2D;

    // Data types below this value are short packets (no payload, WC field is data).
    localparam logic [5:0] DtShortLimit = 6'h10;

    typedef enum logic [1:0] {
        StIdle,
        StHdr1,
        StPayload,
        StDrain
    } state_e;

    function automatic logic is_raw_dt(input logic [5:0] dt);
        return (dt == DtRaw10) || (dt == DtRaw12) || (dt == DtRaw14);
    endfunction

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// CSI-2 packet header ECC generator (6-bit Hamming code, no correction).
//   data_i : 24-bit header payload {WC[15:0], DI[7:0]}
//   ecc_o  : 6 parity bits; the transmitted ECC byte carries these in [5:0] with [7:6] = 0
// Purely combinational.
module mipi_csi_header_ecc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    // Each mask selects the data bits covered by one parity bit.
    localparam logic [23:0] MaskP0 = 24'hF1_2CB7;
    localparam logic [23:0] MaskP1 = 24'hF2_555B;
    localparam logic [23:0] MaskP2 = 24'h74_9A6D;
    localparam logic [23:0] MaskP3 = 24'hB8_E38E;
    localparam logic [23:0] MaskP4 = 24'hDF_03F0;
    localparam logic [23:0] MaskP5 = 24'hEF_FC00;

    always_comb begin
        ecc_o[0] = ^(data_i & MaskP0);
        ecc_o[1] = ^(data_i & MaskP1);
        ecc_o[2] = ^(data_i & MaskP2);
        ecc_o[3] = ^(data_i & MaskP3);
        ecc_o[4] = ^(data_i & MaskP4);
        ecc_o[5] = ^(data_i & MaskP5);
    end

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// CSI-2 2-lane packet decoder: parses the 4-byte header carried on two 16-bit beats, pulses
// frame markers for FS/FE short packets and forwards RAW10/12/14 long-packet payload words.
//
// Ports:
//   clk_i          : byte clock
//   reset_i        : synchronous, active-high reset
//   data_valid_i   : aligned lane data valid (high for the whole packet burst)
//   data_i[15:0]   : lane 0 byte in [7:0] (earlier), lane 1 byte in [15:8]
//   output_valid_o : payload word valid (1-cycle latency from input beat)
//   data_o[15:0]   : payload word, same byte order as data_i
//   packet_type_o  : DT[2:0] of the last accepted RAW long packet, set before its first word
//   frame_start_o  : 1-cycle pulse on accepted Frame Start
//   frame_end_o    : 1-cycle pulse on accepted Frame End
//   ecc_error_o    : 1-cycle pulse on header ECC mismatch
//
// Build option: define PACKET_DECODER_ECC_CHECK_EN to check the header ECC and drop packets whose
// ECC mismatches. Without it the ECC byte is ignored and ecc_error_o stays 0.
module mipi_csi_rx_packet_decoder_8b2lane
    import mipi_csi_pkg::*;
#(
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [15:0] data_i,
    output logic        output_valid_o,
    output logic [15:0] data_o,
    output logic [2:0]  packet_type_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        ecc_error_o
);

    state_e      state_q;
    logic [15:0] h0_q;
    logic [15:0] count_q;
    logic        dv_prev_q;

    // Header fields, valid while in StHdr1 (H0 registered, H1 on the input).
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic [7:0]  hdr_ecc;
    logic        hdr_vc_ok;
    logic        hdr_ecc_bad;

    assign hdr_vc    = h0_q[7:6];
    assign hdr_dt    = h0_q[5:0];
    assign hdr_wc    = {data_i[7:0], h0_q[15:8]};
    assign hdr_ecc   = data_i[15:8];
    assign hdr_vc_ok = (hdr_vc == VIRTUAL_CHANNEL);

`ifdef PACKET_DECODER_ECC_CHECK_EN
    logic [5:0] ecc_calc;

    mipi_csi_header_ecc u_header_ecc (
        .data_i ({hdr_wc, h0_q[7:0]}),
        .ecc_o  (ecc_calc)
    );

    assign hdr_ecc_bad = (hdr_ecc != {2'b00, ecc_calc});
`else
    logic unused_hdr_ecc;
    assign unused_hdr_ecc = ^hdr_ecc;
    assign hdr_ecc_bad    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        // Tracks the previous data_valid_i level, including through reset, so that a burst still
        // in flight when reset releases is not mistaken for a new header.
        dv_prev_q <= data_valid_i;

        if (reset_i) begin
            state_q        <= StIdle;
            h0_q           <= '0;
            count_q        <= '0;
            output_valid_o <= 1'b0;
            data_o         <= '0;
            packet_type_o  <= '0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            ecc_error_o    <= 1'b0;
        end else begin
            output_valid_o <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            ecc_error_o    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (data_valid_i && !dv_prev_q) begin
                        h0_q    <= data_i;
                        state_q <= StHdr1;
                    end
                end

                StHdr1: begin
                    if (!data_valid_i) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StDrain;
                        if (!hdr_vc_ok) begin
                            // Other virtual channel: skip silently.
                        end else if (hdr_ecc_bad) begin
                            ecc_error_o <= 1'b1;
                        end else if (hdr_dt < DtShortLimit) begin
                            frame_start_o <= (hdr_dt == DtFrameStart);
                            frame_end_o   <= (hdr_dt == DtFrameEnd);
                        end else if (is_raw_dt(hdr_dt) && (hdr_wc != 16'd0)) begin
                            packet_type_o <= hdr_dt[2:0];
                            count_q       <= hdr_wc;
                            state_q       <= StPayload;
                        end
                    end
                end

                StPayload: begin
                    if (!data_valid_i) begin
                        state_q <= StIdle;
                    end else begin
                        output_valid_o <= 1'b1;
                        data_o         <= data_i;
                        // Two bytes per beat; an odd final byte still consumes a whole beat.
                        if (count_q <= 16'd2) begin
                            count_q <= '0;
                            state_q <= StDrain;
                        end else begin
                            count_q <= count_q - 16'd2;
                        end
                    end
                end

                StDrain: begin
                    if (!data_valid_i) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
module tb_mipi_csi_rx_packet_decoder_8b2lane;

    localparam logic [1:0] VC = 2'd0;
`ifdef PACKET_DECODER_ECC_CHECK_EN
    localparam bit EccEn = 1'b1;
`else
    localparam bit EccEn = 1'b0;
`endif

    // ECC contribution of each header bit (bit i of {WC, DI}).
    localparam logic [5:0] EccCol [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    logic        clk = 1'b0;
    logic        reset_i;
    logic        data_valid_i;
    logic [15:0] data_i;
    logic        output_valid_o;
    logic [15:0] data_o;
    logic [2:0]  packet_type_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        ecc_error_o;

    mipi_csi_rx_packet_decoder_8b2lane #(
        .VIRTUAL_CHANNEL (VC)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .output_valid_o (output_valid_o),
        .data_o         (data_o),
        .packet_type_o  (packet_type_o),
        .frame_start_o  (frame_start_o),
        .frame_end_o    (frame_end_o),
        .ecc_error_o    (ecc_error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: collects everything the DUT emits, tagged with the cycle it was seen in.
    int          got_cyc[$];
    logic [15:0] got_word[$];
    int          fs_cyc[$];
    int          fe_cyc[$];
    int          ecc_cyc[$];

    always @(negedge clk) begin
        if (output_valid_o === 1'b1) begin
            got_cyc.push_back(cyc);
            got_word.push_back(data_o);
        end
        if (frame_start_o === 1'b1) fs_cyc.push_back(cyc);
        if (frame_end_o === 1'b1)   fe_cyc.push_back(cyc);
        if (ecc_error_o === 1'b1)   ecc_cyc.push_back(cyc);
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2:0] exp_type = 3'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_ecc(input logic [23:0] hdr);
        logic [5:0] e = '0;
        for (int i = 0; i < 24; i++) begin
            if (hdr[i]) e = e ^ EccCol[i];
        end
        return {2'b00, e};
    endfunction

    task automatic drive(input logic v, input logic [15:0] d);
        data_valid_i = v;
        data_i       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_cyc.delete();
        got_word.delete();
        fs_cyc.delete();
        fe_cyc.delete();
        ecc_cyc.delete();
    endtask

    // Send one packet. n_after = beats with data_valid high after H1 (-1: stop after H0).
    // seq_payload selects the 0x0201, 0x0403, ... word pattern instead of random words.
    task automatic send_pkt(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input int n_after, input logic [7:0] ecc_flip,
                            input bit seq_payload);
        logic [7:0]  di;
        logic [7:0]  ecc;
        logic [15:0] pay[$];
        logic [15:0] w;
        int          n0;
        bit          hdr_done;
        bit          vc_ok;
        bit          ecc_ok;
        bit          accepted;
        bit          long_ok;
        int          exp_words;
        int          exp_fs;
        int          exp_fe;
        int          exp_ecc;

        di       = {vc, dt};
        ecc      = model_ecc({wc, di}) ^ ecc_flip;
        hdr_done = (n_after >= 0);
        vc_ok    = (vc == VC);
        ecc_ok   = !EccEn || (ecc == model_ecc({wc, di}));
        accepted = hdr_done && vc_ok && ecc_ok;
        long_ok  = accepted && (dt inside {6'h2B, 6'h2C, 6'h2D}) && (wc != 16'd0);
        if (long_ok) exp_type = dt[2:0];
        exp_words = long_ok ? (((int'(wc) + 1) / 2 < n_after) ? (int'(wc) + 1) / 2 : n_after) : 0;
        exp_fs    = (accepted && dt == 6'h00) ? 1 : 0;
        exp_fe    = (accepted && dt == 6'h01) ? 1 : 0;
        exp_ecc   = (EccEn && hdr_done && vc_ok && !ecc_ok) ? 1 : 0;

        clear_mon();
        n0 = cyc;
        drive(1'b1, {wc[7:0], di});
        if (hdr_done) begin
            drive(1'b1, {ecc, wc[15:8]});
            // Cycle n0+2: header results are visible, payload not yet.
            chk({tag, " type_at_hdr"}, packet_type_o, exp_type);
            chk({tag, " valid_at_hdr"}, output_valid_o, 1'b0);
            for (int i = 0; i < n_after; i++) begin
                w = seq_payload ? {8'(2 * i + 2), 8'(2 * i + 1)} : 16'($urandom);
                pay.push_back(w);
                drive(1'b1, w);
            end
        end
        repeat (4) drive(1'b0, 16'($urandom));

        chk({tag, " word_count"}, got_word.size(), exp_words);
        for (int i = 0; i < exp_words && i < got_word.size(); i++) begin
            chk({tag, " word"}, got_word[i], pay[i]);
            chk({tag, " word_cycle"}, got_cyc[i], n0 + 3 + i);
        end
        chk({tag, " fs_count"}, fs_cyc.size(), exp_fs);
        if (exp_fs == 1 && fs_cyc.size() == 1) chk({tag, " fs_cycle"}, fs_cyc[0], n0 + 2);
        chk({tag, " fe_count"}, fe_cyc.size(), exp_fe);
        if (exp_fe == 1 && fe_cyc.size() == 1) chk({tag, " fe_cycle"}, fe_cyc[0], n0 + 2);
        chk({tag, " ecc_count"}, ecc_cyc.size(), exp_ecc);
        if (exp_ecc == 1 && ecc_cyc.size() == 1) chk({tag, " ecc_cycle"}, ecc_cyc[0], n0 + 2);
        chk({tag, " type_after"}, packet_type_o, exp_type);
    endtask

    initial begin
        logic [15:0] w0;
        logic [15:0] w1;
        logic [5:0]  dts [7];
        logic [1:0]  r_vc;
        logic [5:0]  r_dt;
        logic [15:0] r_wc;
        int          r_n;
        logic [7:0]  r_flip;
        int          nw;

        dts = '{6'h00, 6'h01, 6'h2B, 6'h2C, 6'h2D, 6'h2A, 6'h12};

        reset_i      = 1'b1;
        data_valid_i = 1'b0;
        data_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", output_valid_o, 1'b0);
        chk("reset data", data_o, 16'h0);
        chk("reset type", packet_type_o, 3'd0);
        chk("reset fs", frame_start_o, 1'b0);
        chk("reset fe", frame_end_o, 1'b0);
        chk("reset ecc", ecc_error_o, 1'b0);
        reset_i = 1'b0;
        repeat (2) drive(1'b0, 16'h0);

        send_pkt("fs", VC, 6'h00, 16'h0001, 0, 8'h00, 1'b0);
        send_pkt("raw10", VC, 6'h2B, 16'd10, 6, 8'h00, 1'b1);
        send_pkt("raw12_vc1", 2'd1, 6'h2C, 16'd12, 7, 8'h00, 1'b0);
        send_pkt("raw14_drop", VC, 6'h2D, 16'd12, 2, 8'h00, 1'b0);
        send_pkt("fe", VC, 6'h01, 16'h0000, 0, 8'h00, 1'b0);
        send_pkt("ecc_flip", VC, 6'h2C, 16'd8, 5, 8'h04, 1'b0);
        send_pkt("odd_wc", VC, 6'h2D, 16'd5, 4, 8'h00, 1'b0);
        send_pkt("wc_zero", VC, 6'h2B, 16'd0, 1, 8'h00, 1'b0);
        send_pkt("raw8_skip", VC, 6'h2A, 16'd4, 3, 8'h00, 1'b0);
        send_pkt("hdr_abort", VC, 6'h2D, 16'd4, -1, 8'h00, 1'b0);

        // Reset for one cycle in the middle of a RAW12 payload; the rest of the burst is ignored.
        clear_mon();
        begin
            int n0;
            n0 = cyc;
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            drive(1'b1, {8'd12, VC, 6'h2C});
            drive(1'b1, {model_ecc({16'd12, VC, 6'h2C}), 8'h00});
            drive(1'b1, w0);
            drive(1'b1, w1);
            reset_i = 1'b1;
            drive(1'b1, 16'($urandom));
            reset_i  = 1'b0;
            exp_type = 3'd0;
            chk("rst_mid valid", output_valid_o, 1'b0);
            chk("rst_mid data", data_o, 16'h0);
            chk("rst_mid type", packet_type_o, 3'd0);
            repeat (4) drive(1'b1, 16'($urandom));
            repeat (4) drive(1'b0, 16'h0);
            chk("rst_mid words", got_word.size(), 2);
            if (got_word.size() >= 2) begin
                chk("rst_mid w0", got_word[0], w0);
                chk("rst_mid w1", got_word[1], w1);
                chk("rst_mid w0 cycle", got_cyc[0], n0 + 3);
            end
            chk("rst_mid type_hold", packet_type_o, 3'd0);
        end
        send_pkt("fe_after_rst", VC, 6'h01, 16'h0003, 0, 8'h00, 1'b0);

        for (int k = 0; k < 30; k++) begin
            r_vc   = ($urandom_range(0, 3) == 0) ? 2'd1 : VC;
            r_dt   = dts[$urandom_range(0, 6)];
            r_wc   = 16'($urandom_range(0, 24));
            nw     = (int'(r_wc) + 1) / 2;
            r_n    = (r_dt < 6'h10) ? 0 : nw + 1;
            if (r_dt >= 6'h10 && $urandom_range(0, 3) == 0) r_n = $urandom_range(0, nw);
            r_flip = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            send_pkt("rand", r_vc, r_dt, r_wc, r_n, r_flip, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
